// File: rtl/boot_pkg.sv
// Shared definitions for the boot loaders: loader state encoding, stream
// framing constants and the length-bound helper.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  localparam int unsigned BOOT_LEN_BYTES  = 2;
  localparam int unsigned BOOT_WORD_BYTES = 4;

  // True when a requested word count does not fit a 2^addr_w word memory.
  function automatic logic len_overflow(input logic [8*BOOT_LEN_BYTES-1:0] n,
                                        input int unsigned addr_w);
    return 32'(n) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Byte-to-word packer: collects BOOT_WORD_BYTES bytes MSB first.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   byte_en_i      a byte is consumed this cycle
//   byte_i         the byte being consumed
//   word_valid_o   high in the cycle the final byte of a word is consumed
//   word_o         assembled word, valid together with word_valid_o
// The completion outputs are combinational so the consumer can register the
// write in the same edge that takes the last byte.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int unsigned CNT_W = $clog2(BOOT_WORD_BYTES);
  localparam int unsigned SH_W  = 8 * (BOOT_WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BOOT_WORD_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0]  sh_q, sh_d;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (byte_en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      sh_d  = {sh_q[SH_W-9:0], byte_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign word_valid_o = byte_en_i && (cnt_q == LAST);
  assign word_o       = {sh_q, byte_i};

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-serial instruction-memory loader. Receives a big-endian 16-bit word
// count, then that many big-endian 32-bit words, writes them to imem at
// consecutive addresses from 0 and holds the CPU in reset until complete.
// Optional feature macro: BOOT_CHECKSUM_EN -- when defined, one trailing
// byte equal to the XOR of all payload bytes is required; a mismatch
// ends in the error state.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   byte_valid/byte_data/byte_ready  byte stream handshake
//   imem_we/imem_addr/imem_wdata registered one-cycle write port
//   cpu_rst                      CPU reset, released with done
//   done, err                    sticky completion / failure flags
//   words_loaded                 count of words written so far
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  boot_state_e       state_q;
  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   words_nxt;
  logic              byte_ready_q, we_q, cpu_rst_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  logic                        accept;
  logic [8*BOOT_LEN_BYTES-1:0] n_full;
  logic                        word_valid;
  logic [31:0]                 word;

  assign accept    = byte_valid && byte_ready_q;
  assign n_full    = {len_hi_q, byte_data};
  assign words_nxt = words_q + (ADDR_W+1)'(1);

  boot_word_packer u_packer (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_en_i    (accept && (state_q == ST_DATA)),
    .byte_i       (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LEN_HI;
      len_hi_q     <= '0;
      len_q        <= '0;
      words_q      <= '0;
      byte_ready_q <= 1'b1;
      we_q         <= 1'b0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_LEN_HI: begin
          if (accept) begin
            len_hi_q <= byte_data;
            state_q  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            if (len_overflow(n_full, ADDR_W)) begin
              state_q      <= ST_ERR;
              err_q        <= 1'b1;
              byte_ready_q <= 1'b0;
            end else if (n_full == '0) begin
`ifdef BOOT_CHECKSUM_EN
              state_q      <= ST_CSUM;
`else
              state_q      <= ST_DONE;
              done_q       <= 1'b1;
              cpu_rst_q    <= 1'b0;
              byte_ready_q <= 1'b0;
`endif
            end else begin
              len_q   <= (ADDR_W+1)'(n_full);
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            xor_q <= xor_q ^ byte_data;
`endif
            if (word_valid) begin
              we_q    <= 1'b1;
              addr_q  <= words_q[ADDR_W-1:0];
              wdata_q <= word;
              words_q <= words_nxt;
              if (words_nxt == len_q) begin
`ifdef BOOT_CHECKSUM_EN
                state_q      <= ST_CSUM;
`else
                // done follows one cycle later, from the DONE state
                state_q      <= ST_DONE;
                byte_ready_q <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            byte_ready_q <= 1'b0;
            if (byte_data == xor_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          done_q       <= 1'b1;
          cpu_rst_q    <= 1'b0;
          byte_ready_q <= 1'b0;
        end
        ST_ERR: begin
          byte_ready_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_ERR;
          err_q        <= 1'b1;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-serial program loader sitting directly upstream of `mips_cpu`. It fills the instruction memory with a word stream and holds the CPU in reset until the whole image is written, so the core never fetches a partially loaded program. It replaces hard-coded `$readmemh` images in system-level benches and in the FPGA top.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; capacity 2^ADDR_W words.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `byte_valid`  in  1  a source byte is present.
- `byte_data`  in  8  source byte.
- `byte_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_rst`  out  1  reset to `mips_cpu`; high until load completes.
- `done`  out  1  image loaded; sticky until `rst`.
- `err`  out  1  load failed; sticky until `rst`.
- `words_loaded`  out  ADDR_W+1  count of words written so far.

## Operation
- Stream format, in order:
  - 16-bit word count N, big-endian.
  - N words, 4 bytes each, big-endian (MSB first).
  - With checksum enabled, 1 checksum byte: XOR of all payload bytes. Header bytes are excluded.
- Handshake: a byte is accepted on a rising edge where `byte_valid && byte_ready`. The source may drop `byte_valid` for any number of cycles; gaps have no effect.
- `byte_ready` is 1 in the receive states and 0 in DONE and ERR.
- States:
  - LEN_HI: accept a byte, go to LEN_LO.
  - LEN_LO: accept a byte.
    - If N > 2^ADDR_W, go to ERR.
    - If N == 0, go to CSUM (checksum enabled) or DONE.
    - Otherwise go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into a 32-bit word. When the 4th byte is accepted, the write is issued and the word index increments. After the Nth word, go to CSUM or DONE.
  - CSUM: accept a byte and compare it with the running XOR. Match goes to DONE; mismatch goes to ERR.
  - DONE, ERR: terminal; leave only on `rst`.
- Address wrap cannot occur: N is bounded by the LEN_LO check.
- Reset mid-load:
  - State returns to LEN_HI and all counters and the XOR clear.
  - `cpu_rst` returns to 1.
  - Memory contents already written are left untouched, not cleared.
- Reset values: `byte_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0, `words_loaded`=0.

## Timing
- `imem_we`, `imem_addr` and `imem_wdata` are registered. `imem_we` pulses exactly one cycle, in the cycle after the 4th byte of a word is accepted.
- `imem_addr` equals the word index, 0 to N-1, in strict order.
- `words_loaded` increments in the same cycle as `imem_we`.
- A byte accepted during a write-pulse cycle is legal, so sustained throughput is 1 byte/cycle.
- `done` rises and `cpu_rst` falls together, one cycle after the later of:
  - the final `imem_we` pulse, and
  - checksum-byte acceptance (checksum enabled only).
- `err` rises in the cycle after the failing byte is accepted. `cpu_rst` stays 1 and `done` stays 0.
- N==0 with checksum disabled: `done` rises 1 cycle after the LEN_LO byte is accepted.

## Configuration
- Macro `BOOT_CHECKSUM_EN`:
  - Defined: the CSUM state and XOR accumulator are present; a mismatch sets `err`.
  - Undefined: no checksum byte is expected, and the stream ends after the last data byte. The XOR logic is absent and `err` is asserted only on length overflow.

## Structure
- Shared package `boot_pkg`:
  - state enum (LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - `BOOT_LEN_BYTES`=2;
  - `BOOT_WORD_BYTES`=4.
- Sub-module `boot_word_packer`: byte counter plus shift register. It emits a word-valid pulse and the 32-bit word. It is reused later by the data-memory loader.

## Test plan
- Base load, ADDR_W=8, checksum enabled: bytes 00 02 20 01 00 0A 20 02 00 14 1D -> writes addr0=0x2001000A and addr1=0x20020014; `words_loaded`=2; `done`=1 and `cpu_rst`=0 one cycle after the later of the last write and the checksum.
- Empty image: 00 00 00 -> no `imem_we`; `done`=1; `err`=0.
- Bad checksum: base stream with final byte 1C -> both writes occur; `err`=1; `cpu_rst` stays 1; `byte_ready`=0.
- Length overflow: 01 01 (N=257) -> `err`=1 after the second byte; no writes.
- Random 0-5 cycle `byte_valid` gaps on the base stream -> identical writes and final state to the base load.
- `rst` for one cycle after 5 bytes of the base stream:
  - all outputs return to reset values;
  - a full reload then gives the base-load result.
